// File: rtl/irq_timer_pkg.sv
// Shared types for the interrupt timer bank.
//   cmd_op_e   : command encoding carried on cmd_op
//   ch_state_e : per-channel state machine encoding
package irq_timer_pkg;

  typedef enum logic [1:0] {
    OP_START        = 2'd0,
    OP_STOP         = 2'd1,
    OP_SET_PRESCALE = 2'd2,
    OP_NOP          = 2'd3
  } cmd_op_e;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/irq_timer_channel.sv
// One countdown timer channel with a sticky interrupt request.
// Ports:
//   clk, RESET          : clock, synchronous active-high reset
//   tick                : shared prescaler enable; the count moves only on ticks
//   start, stop         : one-cycle command strobes for this channel
//   periodic, load      : mode and load value latched on start
//   ack                 : clears irq at the next edge (an expiry on that edge wins)
//   irq                 : registered sticky interrupt request
//   irq_nxt             : value irq takes at the next edge (lets the top register irq_any)
//   running             : channel is in CH_RUN
module irq_timer_channel
  import irq_timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load,
  input  logic             ack,
  output logic             irq,
  output logic             irq_nxt,
  output logic             running
);

  ch_state_e        state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] load_q, load_nxt;
  logic             per_q, per_nxt;
  logic             expire;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state  <= CH_IDLE;
      count  <= '0;
      load_q <= '0;
      per_q  <= 1'b0;
      irq    <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      load_q <= load_nxt;
      per_q  <= per_nxt;
      irq    <= irq_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    load_nxt  = load_q;
    per_nxt   = per_q;
    expire    = 1'b0;

    // START takes priority over everything, including an expiry due on the
    // same edge: the pending expiry is simply discarded.
    if (start) begin
      state_nxt = CH_RUN;
      count_nxt = load;
      load_nxt  = load;
      per_nxt   = periodic;
    end else begin
      unique case (state)
        CH_IDLE: ;
        CH_RUN: begin
          if (stop) begin
            state_nxt = CH_IDLE;          // count frozen, irq untouched
          end else if (tick) begin
            if (count == '0) begin
              expire = 1'b1;
              if (per_q) count_nxt = load_q;
              else       state_nxt = CH_IDLE;
            end else begin
              count_nxt = count - CNT_W'(1);
            end
          end
        end
        default: state_nxt = CH_IDLE;
      endcase
    end

    // Set beats acknowledge.
    irq_nxt = expire | (irq & ~ack);
  end

  assign running = (state == CH_RUN);

endmodule

// File: rtl/irq_timer_bank.sv
// Bank of NUM_CH countdown timers sharing one prescaler.
// Ports:
//   clk, RESET        : clock, synchronous active-high reset
//   cmd_valid         : command strobe, always accepted
//   cmd_op            : START / STOP / SET_PRESCALE / NOP
//   cmd_ch            : target channel for START and STOP (out-of-range ignored)
//   cmd_load          : START load value; low PRE_W bits are the SET_PRESCALE divisor
//   cmd_periodic      : START mode, 1 = periodic
//   irq_ack           : per-channel acknowledge
//   irq               : sticky per-channel interrupt requests
//   irq_any           : registered OR of the next-state irq vector
//   running           : per-channel RUN indication
module irq_timer_bank
  import irq_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PRE_W  = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [CNT_W-1:0]  cmd_load,
  input  logic              cmd_periodic,
  input  logic [NUM_CH-1:0] irq_ack,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any,
  output logic [NUM_CH-1:0] running
);

  logic [PRE_W-1:0]  pre_div;
  logic [PRE_W-1:0]  pre_cnt;
  logic              tick;
  logic              set_pre;
  logic [NUM_CH-1:0] start_vec;
  logic [NUM_CH-1:0] stop_vec;
  logic [NUM_CH-1:0] irq_nxt;

  assign set_pre = cmd_valid && (cmd_op == OP_SET_PRESCALE);
  assign tick    = (pre_cnt == pre_div);

  // Shared prescaler: pre_cnt walks 0..pre_div; a new divisor restarts the phase.
  always_ff @(posedge clk) begin
    if (RESET) begin
      pre_div <= '0;
      pre_cnt <= '0;
    end else if (set_pre) begin
      pre_div <= cmd_load[PRE_W-1:0];
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // One-hot decode; indices at or above NUM_CH match no channel and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign start_vec[i] = cmd_valid && (cmd_op == OP_START) && (cmd_ch == CH_W'(i));
    assign stop_vec[i]  = cmd_valid && (cmd_op == OP_STOP)  && (cmd_ch == CH_W'(i));

    irq_timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .RESET    (RESET),
      .tick     (tick),
      .start    (start_vec[i]),
      .stop     (stop_vec[i]),
      .periodic (cmd_periodic),
      .load     (cmd_load),
      .ack      (irq_ack[i]),
      .irq      (irq[i]),
      .irq_nxt  (irq_nxt[i]),
      .running  (running[i])
    );
  end

  // Registered from the next-state vector so irq_any lines up with irq.
  always_ff @(posedge clk) begin
    if (RESET) irq_any <= 1'b0;
    else       irq_any <= |irq_nxt;
  end

endmodule
